// File: rtl/interrupt_arbiter_if.sv
// Interrupt arbiter port bundle: peripheral request lines, CPU trap handshake,
// data bus slave signals and a debug view of the arbiter FSM state.
//
// Handshake: the arbiter raises cpu_irq_req (with cpu_irq_cause stable) and
// holds it until either the core pulses cpu_irq_ack (request consumed, trap
// taken) or the line becomes ineligible before an ack arrives (request
// withdrawn). After an ack the core signals end of handler with cpu_irq_done.
interface interrupt_arbiter_if #(
    parameter int NUM_IRQ = 8
);
    logic [NUM_IRQ-1:0] irq_n;
    logic               cpu_irq_req;
    logic [3:0]         cpu_irq_cause;
    logic               cpu_irq_ack;
    logic               cpu_irq_done;
    logic [15:0]        data_bus_write;
    logic [15:0]        data_bus_read;
    logic [31:0]        data_bus_addr;
    logic [1:0]         data_bus_mode;
    logic               data_bus_select;
    logic [1:0]         fsm_state;

    modport master (
        output irq_n, cpu_irq_ack, cpu_irq_done,
        output data_bus_write, data_bus_addr, data_bus_mode, data_bus_select,
        input  cpu_irq_req, cpu_irq_cause, data_bus_read, fsm_state
    );

    modport slave (
        input  irq_n, cpu_irq_ack, cpu_irq_done,
        input  data_bus_write, data_bus_addr, data_bus_mode, data_bus_select,
        output cpu_irq_req, cpu_irq_cause, data_bus_read, fsm_state
    );
endinterface

// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: latches active-low request pulses into sticky pending
// flags, masks them, picks the lowest index and runs a req/ack/done handshake
// with the core. Registers: MASK +0x0, PENDING +0x4 (W1C), ACTIVE +0x8,
// CTRL +0xC (bit0 enable), OVERFLOW +0x10.
// Optional feature macro: INTERRUPT_ARBITER_OVERFLOW_EN enables the OVERFLOW
// register (new falling edge while already pending); otherwise it reads 0.
module interrupt_arbiter #(
    parameter int          NUM_IRQ   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h4000
) (
    input  logic clk,
    input  logic reset,
    interrupt_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQUEST = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t             state_q;
    logic               req_q;
    logic [3:0]         cause_q;
    logic [NUM_IRQ-1:0] irq_sync;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] active_q;
    logic               enable_q;

    logic               wr_en;
    logic               hit_mask;
    logic               hit_pend;
    logic               hit_ctrl;
    logic [NUM_IRQ-1:0] wr_data;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] cause_onehot;
    logic               cause_eligible;
    logic               any_eligible;
    logic [3:0]         win_idx;
    logic               ack_take;
    logic [NUM_IRQ-1:0] pend_clr;
    logic [NUM_IRQ-1:0] pending_nxt;
    logic [NUM_IRQ-1:0] ovf_view;
    logic [15:0]        rd_data;
    logic               unused_bits;

    assign wr_en    = (bus.data_bus_mode == 2'b10) && bus.data_bus_select;
    assign hit_mask = wr_en && (bus.data_bus_addr == BASE_ADDR);
    assign hit_pend = wr_en && (bus.data_bus_addr == BASE_ADDR + 32'h4);
    assign hit_ctrl = wr_en && (bus.data_bus_addr == BASE_ADDR + 32'hC);
    assign wr_data  = bus.data_bus_write[NUM_IRQ-1:0];

    // Upper write-data bits beyond the implemented lines carry no meaning.
    assign unused_bits = ^bus.data_bus_write;

    assign eligible       = pending_q & mask_q & {NUM_IRQ{enable_q}};
    assign any_eligible   = |eligible;
    assign cause_onehot   = NUM_IRQ'(1) << cause_q;
    assign cause_eligible = |(eligible & cause_onehot);
    assign ack_take       = (state_q == S_REQUEST) && bus.cpu_irq_ack;

    // Fixed priority: scan downwards so the lowest eligible index is kept.
    always_comb begin
        win_idx = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) win_idx = 4'(i);
        end
    end

    // Sticky pending: W1C and ack clear first, then new requests set (set wins).
    always_comb begin
        pend_clr = '0;
        if (hit_pend) pend_clr = pend_clr | wr_data;
        if (ack_take) pend_clr = pend_clr | cause_onehot;
        pending_nxt = (pending_q & ~pend_clr) | ~irq_sync;
    end

    // Input stage, configuration registers and pending flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_sync  <= '1;
            mask_q    <= '0;
            enable_q  <= 1'b0;
            pending_q <= '0;
        end else begin
            irq_sync  <= bus.irq_n;
            pending_q <= pending_nxt;
            if (hit_mask) mask_q   <= wr_data;
            if (hit_ctrl) enable_q <= bus.data_bus_write[0];
        end
    end

`ifdef INTERRUPT_ARBITER_OVERFLOW_EN
    logic               hit_ovf;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] ovf_q;
    logic [NUM_IRQ-1:0] ovf_set;

    assign hit_ovf = wr_en && (bus.data_bus_addr == BASE_ADDR + 32'h10);
    // A fresh falling edge on a line whose previous request is still pending.
    assign ovf_set = ~irq_sync & pending_q & irq_prev_q;

    // Overflow flags: W1C with set taking precedence.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_prev_q <= '1;
            ovf_q      <= '0;
        end else begin
            irq_prev_q <= irq_sync;
            ovf_q      <= (ovf_q & ~(hit_ovf ? wr_data : '0)) | ovf_set;
        end
    end

    assign ovf_view = ovf_q;
`else
    assign ovf_view = '0;
`endif

    // Request/acknowledge/done handshake with registered req and cause.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            cause_q  <= 4'd0;
            active_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_eligible) begin
                        state_q <= S_REQUEST;
                        req_q   <= 1'b1;
                        cause_q <= win_idx;
                    end
                end
                S_REQUEST: begin
                    if (bus.cpu_irq_ack) begin
                        state_q  <= S_SERVICE;
                        req_q    <= 1'b0;
                        active_q <= cause_onehot;
                    end else if (!cause_eligible) begin
                        state_q <= S_IDLE;
                        req_q   <= 1'b0;
                    end
                end
                S_SERVICE: begin
                    if (bus.cpu_irq_done) begin
                        state_q  <= S_IDLE;
                        active_q <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    // Register readback, decoded from the address alone.
    always_comb begin
        rd_data = '0;
        if (bus.data_bus_addr == BASE_ADDR)
            rd_data[NUM_IRQ-1:0] = mask_q;
        else if (bus.data_bus_addr == BASE_ADDR + 32'h4)
            rd_data[NUM_IRQ-1:0] = pending_q;
        else if (bus.data_bus_addr == BASE_ADDR + 32'h8)
            rd_data[NUM_IRQ-1:0] = active_q;
        else if (bus.data_bus_addr == BASE_ADDR + 32'hC)
            rd_data[0] = enable_q;
        else if (bus.data_bus_addr == BASE_ADDR + 32'h10)
            rd_data[NUM_IRQ-1:0] = ovf_view;
    end

    assign bus.cpu_irq_req   = req_q;
    assign bus.cpu_irq_cause = cause_q;
    assign bus.data_bus_read = rd_data;
    assign bus.fsm_state     = state_q;
endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed bench for interrupt_arbiter: stimulus pushes expectations into a
// queue, a negedge monitor pops and compares them against the DUT outputs.
module tb_interrupt_arbiter;
    localparam int          N      = 8;
    localparam logic [31:0] A_MASK = 32'h4000;
    localparam logic [31:0] A_PEND = 32'h4004;
    localparam logic [31:0] A_ACT  = 32'h4008;
    localparam logic [31:0] A_CTRL = 32'h400C;
    localparam logic [31:0] A_OVF  = 32'h4010;
    localparam logic [31:0] A_BAD  = 32'h4014;

`ifdef INTERRUPT_ARBITER_OVERFLOW_EN
    localparam logic [15:0] OVF_EXP = 16'h0040;
`else
    localparam logic [15:0] OVF_EXP = 16'h0000;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    interrupt_arbiter_if #(.NUM_IRQ(N)) ifc ();

    interrupt_arbiter #(.NUM_IRQ(N), .BASE_ADDR(32'h4000)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    // ---------------- scoreboard ----------------
    // sel: 0 = data_bus_read, 1 = cpu_irq_req, 2 = cpu_irq_cause
    logic [15:0] exp_q[$];
    int          sel_q[$];
    string       name_q[$];
    logic        chk_stb = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    logic [15:0] m_exp;
    logic [15:0] m_act;
    int          m_sel;
    string       m_name;

    always @(negedge clk) begin
        if (chk_stb) begin
            while (exp_q.size() > 0) begin
                m_exp  = exp_q.pop_front();
                m_sel  = sel_q.pop_front();
                m_name = name_q.pop_front();
                case (m_sel)
                    0:       m_act = ifc.data_bus_read;
                    1:       m_act = {15'b0, ifc.cpu_irq_req};
                    default: m_act = {12'b0, ifc.cpu_irq_cause};
                endcase
                n_vec++;
                if (m_act !== m_exp) begin
                    n_err++;
                    $display("FAIL %s: got %h expected %h at %0t", m_name, m_act, m_exp, $time);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        chk_stb = 1'b1;
        @(posedge clk);
        #1;
        chk_stb = 1'b0;
    endtask

    task automatic expect_reg(input string name, input logic [31:0] addr, input logic [15:0] val);
        ifc.data_bus_addr = addr;
        exp_q.push_back(val);
        sel_q.push_back(0);
        name_q.push_back(name);
    endtask

    task automatic expect_req(input string name, input logic val);
        exp_q.push_back({15'b0, val});
        sel_q.push_back(1);
        name_q.push_back(name);
    endtask

    task automatic expect_cause(input string name, input logic [3:0] val);
        exp_q.push_back({12'b0, val});
        sel_q.push_back(2);
        name_q.push_back(name);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [15:0] data);
        ifc.data_bus_addr   = addr;
        ifc.data_bus_write  = data;
        ifc.data_bus_mode   = 2'b10;
        ifc.data_bus_select = 1'b1;
        step();
        ifc.data_bus_mode   = 2'b00;
        ifc.data_bus_select = 1'b0;
    endtask

    // Drive the given lines low for exactly one sampling edge.
    task automatic pulse(input logic [N-1:0] lines);
        ifc.irq_n = ~lines;
        step();
        ifc.irq_n = '1;
    endtask

    task automatic ack_cycle();
        ifc.cpu_irq_ack = 1'b1;
        step();
        ifc.cpu_irq_ack = 1'b0;
    endtask

    task automatic done_cycle();
        ifc.cpu_irq_done = 1'b1;
        step();
        ifc.cpu_irq_done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset               = 1'b1;
        ifc.irq_n           = '1;
        ifc.cpu_irq_ack     = 1'b0;
        ifc.cpu_irq_done    = 1'b0;
        ifc.data_bus_write  = 16'h0;
        ifc.data_bus_addr   = 32'h0;
        ifc.data_bus_mode   = 2'b00;
        ifc.data_bus_select = 1'b0;
        @(posedge clk);
        #1;
        step();
        reset = 1'b0;

        // Reset state
        expect_req("rst_req", 1'b0);
        expect_cause("rst_cause", 4'd0);
        expect_reg("rst_mask", A_MASK, 16'h0);
        step();
        expect_reg("rst_pend", A_PEND, 16'h0);
        step();
        expect_reg("rst_ctrl", A_CTRL, 16'h0);
        step();

        // Basic flow on line 2 with latency
        bus_write(A_MASK, 16'h0004);
        bus_write(A_CTRL, 16'h0001);
        expect_reg("ctrl_rb", A_CTRL, 16'h0001);
        step();
        pulse(8'h04);                              // E0
        expect_reg("l2_pend_e0", A_PEND, 16'h0);
        expect_req("l2_req_e0", 1'b0);
        step();                                    // E1
        expect_reg("l2_pend_e1", A_PEND, 16'h0004);
        expect_req("l2_req_e1", 1'b0);
        step();                                    // E2
        expect_req("l2_req_e2", 1'b1);
        expect_cause("l2_cause", 4'd2);
        step();
        expect_req("l2_req_hold", 1'b1);
        ack_cycle();
        expect_reg("l2_pend_ack", A_PEND, 16'h0);
        expect_req("l2_req_ack", 1'b0);
        expect_cause("l2_cause_svc", 4'd2);
        step();
        expect_reg("l2_active", A_ACT, 16'h0004);
        step();
        done_cycle();
        expect_reg("l2_active_done", A_ACT, 16'h0);
        expect_req("l2_req_done", 1'b0);
        step();

        // Two lines at once: 1 beats 5, then 5 follows
        bus_write(A_MASK, 16'h00FF);
        pulse(8'h22);
        step();
        expect_reg("p15_pend", A_PEND, 16'h0022);
        step();
        expect_req("p15_req1", 1'b1);
        expect_cause("p15_cause1", 4'd1);
        ack_cycle();
        expect_reg("p15_pend_ack", A_PEND, 16'h0020);
        expect_req("p15_req_svc", 1'b0);
        step();
        done_cycle();
        expect_req("p15_req_idle", 1'b0);
        step();
        expect_req("p15_req5", 1'b1);
        expect_cause("p15_cause5", 4'd5);
        ack_cycle();
        done_cycle();
        expect_reg("p15_pend_end", A_PEND, 16'h0);
        step();

        // Masked line 3, unmasked later
        bus_write(A_MASK, 16'h0000);
        pulse(8'h08);
        step();
        step();
        expect_reg("m3_pend", A_PEND, 16'h0008);
        expect_req("m3_req_masked", 1'b0);
        step();
        bus_write(A_MASK, 16'h0008);
        expect_req("m3_req_wr", 1'b0);
        step();
        expect_req("m3_req_rise", 1'b1);
        expect_cause("m3_cause", 4'd3);
        ack_cycle();
        done_cycle();

        // Withdrawal: line 0 requested, then masked off
        bus_write(A_MASK, 16'h0001);
        pulse(8'h01);
        step();
        step();
        expect_req("wd_req", 1'b1);
        expect_cause("wd_cause", 4'd0);
        step();
        bus_write(A_MASK, 16'h0000);
        expect_req("wd_req_wr", 1'b1);
        step();
        expect_req("wd_req_drop", 1'b0);
        expect_reg("wd_pend", A_PEND, 16'h0001);
        step();
        expect_reg("wd_active", A_ACT, 16'h0);
        step();
        bus_write(A_PEND, 16'h0001);
        expect_reg("w1c_pend0", A_PEND, 16'h0);
        step();

        // W1C colliding with a new set on line 4: set wins
        pulse(8'h10);
        bus_write(A_PEND, 16'h0010);
        expect_reg("w1c_collide", A_PEND, 16'h0010);
        step();
        bus_write(A_PEND, 16'h0010);
        expect_reg("w1c_clear", A_PEND, 16'h0);
        step();

        // Stray ack/done while idle
        ifc.cpu_irq_ack  = 1'b1;
        ifc.cpu_irq_done = 1'b1;
        step();
        ifc.cpu_irq_ack  = 1'b0;
        ifc.cpu_irq_done = 1'b0;
        expect_req("stray_req", 1'b0);
        expect_reg("stray_active", A_ACT, 16'h0);
        step();

        // Overflow on line 6 (masked)
        pulse(8'h40);
        step();
        step();
        pulse(8'h40);
        step();
        step();
        expect_reg("ovf_set", A_OVF, OVF_EXP);
        step();
        expect_reg("ovf_pend", A_PEND, 16'h0040);
        step();
        bus_write(A_OVF, 16'h0040);
        expect_reg("ovf_clear", A_OVF, 16'h0);
        step();

        // Unmapped accesses
        bus_write(A_BAD, 16'hFFFF);
        expect_reg("unmapped_rd", A_BAD, 16'h0);
        step();
        expect_reg("mask_after_bad", A_MASK, 16'h0);
        step();

        step();
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/interrupt_arbiter.md
Name: interrupt_arbiter

Overview:
- Receiving end of the peripheral IRQ lines: collects active-low, one-cycle-or-longer request pulses from peripherals (the EIC's `eic_irq` among them).
- Latches each request into a sticky pending flag, masks, and selects by fixed priority.
- Runs a request/acknowledge/done handshake with the CPU trap logic.
- Sits between peripherals and the core; its registers are reachable over the data bus slave interface.

Parameters:
- NUM_IRQ, 8, number of request lines (1..16).
- BASE_ADDR, 32'h4000, byte address of the first register.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- irq_n  input  NUM_IRQ  request lines, active-low, bit 0 highest priority
- cpu_irq_req  output  1  interrupt request to core
- cpu_irq_cause  output  4  index of requested/serviced line
- cpu_irq_ack  input  1  core accepted request (trap entry)
- cpu_irq_done  input  1  core finished handler (mret)
- data_bus_write  input  16  bus write data
- data_bus_read  output  16  bus read data
- data_bus_addr  input  32  bus address
- data_bus_mode  input  2  00 idle, 01 read, 10 write
- data_bus_select  input  1  slave select

Behaviour:
- One clock, `clk`; reset synchronous active-high. While reset is high at a rising edge, all registers clear and the FSM goes to IDLE. `cpu_irq_req`=0 and `cpu_irq_cause`=0 after reset. Reset mid-handshake simply aborts; pending requests are lost.
- Register map (offsets from BASE_ADDR), upper bits above NUM_IRQ read 0:
  - +0x0 MASK (rw)
  - +0x4 PENDING (read; write-1-to-clear)
  - +0x8 ACTIVE (ro, one-hot of line in service, 0 otherwise)
  - +0xC CTRL (rw, bit0 = global enable, other bits read 0)
  - +0x10 OVERFLOW (see optional feature)
- A write occurs when `data_bus_mode`==10 and `data_bus_select`=1, with an exact address match. Unmapped writes are ignored.
- `data_bus_read` is combinational from `data_bus_addr` regardless of `select`/`mode`. Unmapped addresses read 0.
- Input stage: `irq_n` registered once into `irq_sync` (no reset dependency beyond clearing to all-ones).
- Pending: at each edge, PENDING[i] is set if `irq_sync[i]`==0, independent of MASK/enable. If set and W1C hit the same bit in the same cycle, set wins. Level-held lines re-set pending every cycle.
- Eligible = PENDING & MASK, gated by CTRL.bit0. Priority: lowest index wins.
- FSM:
  - IDLE: when eligible!=0, go to REQUEST. `cpu_irq_cause` is latched with the winning index at that edge.
  - REQUEST: `cpu_irq_req`=1.
    - On `cpu_irq_ack`=1: go to SERVICE. At that edge, PENDING[cause] clears and ACTIVE = 1<<cause. `cpu_irq_req` falls on the following cycle.
    - If the latched line becomes ineligible (mask bit or enable cleared, or pending cleared by W1C) without ack: return to IDLE with `req`=0 and no pending change. Ack wins over withdrawal in the same cycle.
  - SERVICE: `cpu_irq_req`=0, `cpu_irq_cause` held. On `cpu_irq_done`=1: ACTIVE clears and the FSM goes to IDLE. A new request can issue on the next edge.
  - No nesting: lines arriving during SERVICE only accumulate in PENDING.
- `cpu_irq_ack` outside REQUEST and `cpu_irq_done` outside SERVICE are ignored.
- Latency: `irq_n` low sampled at edge E0 → PENDING set at E1 → `cpu_irq_req` high after E2 (3 edges), given mask and enable set and the FSM in IDLE.
- Cause stable: `cpu_irq_cause` changes only on IDLE→REQUEST.

Optional Feature:
- Macro: INTERRUPT_ARBITER_OVERFLOW_EN.
- Defined: OVERFLOW register at +0x10, W1C, reset 0. OVERFLOW[i] sets when `irq_sync[i]`==0 on a cycle where PENDING[i] is already 1 and `irq_sync[i]` was 1 the previous cycle (new falling edge while still pending). Set wins over W1C.
- Not defined: +0x10 reads 0, writes ignored, no edge history flop.

Test Plan:
- Reset, then MASK=0x0004 and CTRL=1; pulse `irq_n[2]` low for 1 cycle → PENDING=0x0004 one edge later, `cpu_irq_req`=1 with cause=2 on the third edge; ack → PENDING=0, ACTIVE=0x0004, req=0; done → ACTIVE=0, FSM IDLE.
- MASK=0x00FF; pulse lines 5 and 1 in the same cycle → cause=1 first; after ack+done → cause=5 request issued the next cycle.
- MASK=0, pulse line 3 → PENDING=0x0008, no req; then write MASK=0x0008 → req rises 1 edge after the write with cause=3.
- In REQUEST for line 0, write MASK=0 → req drops next cycle, PENDING bit 0 retained, ACTIVE=0.
- W1C PENDING bit 4 in the same cycle `irq_sync[4]`=0 → PENDING[4] remains 1. Ack/done pulses while IDLE → no state change.
- With INTERRUPT_ARBITER_OVERFLOW_EN: two separate pulses on line 6 while masked → OVERFLOW=0x0040; write 0x0040 to +0x10 → reads 0. Without the macro, +0x10 always reads 0.
